// File: rtl/store_rmw_unit.sv
// Store write path: sw writes the word directly, sh/sb read the aligned word,
// merge the target lane(s) and write the whole word back.
module store_rmw_unit #(
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] T_SW = 2'b00;
   localparam logic [1:0] T_SH = 2'b01;
   localparam logic [1:0] T_SB = 2'b10;

   localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

   logic [2:0]  state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rd_q;
   logic [1:0]  type_q;
   logic [1:0]  cnt;
   logic        err_q;
   logic        req_bad;
   logic [31:0] merged;

   // Legality is decided on the incoming request so a bad one goes straight to DONE.
   always_comb begin
      req_bad = (store_type == 2'b11)
              | ((store_type == T_SW) && (addr[1:0] != 2'b00))
              | ((store_type == T_SH) && addr[0]);
   end

   always_comb begin
      merged = rd_q;
      case (type_q)
         T_SH: begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
         end
         T_SB: begin
            case (addr_q[1:0])
               2'd0:    merged[7:0]   = wdata_q[7:0];
               2'd1:    merged[15:8]  = wdata_q[7:0];
               2'd2:    merged[23:16] = wdata_q[7:0];
               default: merged[31:24] = wdata_q[7:0];
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         type_q  <= '0;
         cnt     <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  type_q  <= store_type;
                  err_q   <= req_bad;
                  if (req_bad)                 state <= S_DONE;
                  else if (store_type == T_SW) state <= S_WRITE;
                  else                         state <= S_READ;
               end
            end
            S_READ: begin
               cnt   <= CNT_INIT;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == 2'd0) begin
                  rd_q  <= mem_rdata;
                  state <= S_WRITE;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            S_WRITE: state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode the state register so reset clears them without waiting for a clock.
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = (type_q == T_SW) ? wdata_q : merged;
   assign mem_wr    = (state == S_WRITE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign err       = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two instances (READ_LAT=1 and 3), each with its own
// word memory, checked against a lane-merge reference model.
`timescale 1ns/1ps
module tb_store_rmw_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  start = 2'b00;
   logic [1:0]  store_type = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        mem_wr [2];
   logic        busy [2];
   logic        done [2];
   logic        err [2];

   int total = 0;
   int bad = 0;

   logic [31:0] mem [2][1024];
   logic [31:0] dp [2][3];
   logic        vp [2][3] = '{default: 1'b0};
   logic        pb [2] = '{default: 1'b0};

   always #5 clk = ~clk;

   store_rmw_unit #(.READ_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .start(start[0]), .store_type(store_type),
      .addr(addr), .wdata(wdata), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]),
      .done(done[0]), .err(err[0]));

   store_rmw_unit #(.READ_LAT(3)) u_lat3 (
      .clk(clk), .reset(reset), .start(start[1]), .store_type(store_type),
      .addr(addr), .wdata(wdata), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]),
      .done(done[1]), .err(err[1]));

   // Read data appears only READ_LAT cycles after the first (read) cycle of a request.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         pb[k]    <= busy[k];
         dp[k][0] <= mem[k][mem_addr[k][11:2]];
         vp[k][0] <= busy[k] && !pb[k] && !mem_wr[k] && !done[k];
         for (int j = 1; j < 3; j++) begin
            dp[k][j] <= dp[k][j-1];
            vp[k][j] <= vp[k][j-1];
         end
      end
   end

   assign mem_rdata[0] = vp[0][0] ? dp[0][0] : 32'h5EED_F00D;
   assign mem_rdata[1] = vp[1][2] ? dp[1][2] : 32'h5EED_F00D;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic bit legal(input logic [1:0] t, input logic [31:0] a);
      return !((t == 2'd3) || (t == 2'd0 && a[1:0] != 2'd0) || (t == 2'd1 && a[0]));
   endfunction

   function automatic int exp_cycles(input int k, input logic [1:0] t, input logic [31:0] a);
      if (!legal(t, a)) return 1;
      return (t == 2'd0) ? 2 : 3 + lat_of(k);
   endfunction

   function automatic logic [31:0] model_word(input logic [1:0] t, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
      int          sh;
      logic [31:0] m;
      case (t)
         2'd0: return d;
         2'd1: begin
            sh = int'(a[1]) * 16;
            m  = 32'h0000_FFFF << sh;
            return (old & ~m) | ((d & 32'h0000_FFFF) << sh);
         end
         2'd2: begin
            sh = int'(a[1:0]) * 8;
            m  = 32'h0000_00FF << sh;
            return (old & ~m) | ((d & 32'h0000_00FF) << sh);
         end
         default: return old;
      endcase
   endfunction

   // Advance to the next sampling point and let the memory absorb any write.
   task automatic tick(input int k);
      @(negedge clk);
      if (mem_wr[k] === 1'b1) mem[k][mem_addr[k][11:2]] = mem_wdata[k];
   endtask

   task automatic issue(input int k, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                        output int dc, output logic e, output int wc, output logic [31:0] wd,
                        output logic [31:0] wa, output int abad, output logic idle_after);
      @(negedge clk);
      store_type = t; addr = a; wdata = d; start[k] = 1'b1;
      tick(k);
      start[k] = 1'b0;
      addr = $urandom; wdata = $urandom; store_type = 2'($urandom);
      dc = -1; e = 1'b0; wc = 0; wd = '0; wa = '0; abad = 0;
      for (int c = 1; c <= 12; c++) begin
         if (busy[k] && mem_addr[k] !== {a[31:2], 2'b00}) abad++;
         if (mem_wr[k] === 1'b1) begin wc++; wd = mem_wdata[k]; wa = mem_addr[k]; end
         if (done[k] === 1'b1) begin dc = c; e = err[k]; break; end
         tick(k);
      end
      tick(k);
      idle_after = (busy[k] === 1'b0) && (done[k] === 1'b0);
   endtask

   task automatic test_reset();
      #3;
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({mem_addr[k], mem_wdata[k], mem_wr[k], busy[k], done[k], err[k]} !== 68'h0) begin
            bad++;
            $display("FAIL reset_state k=%0d got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b want all 0",
                     k, mem_addr[k], mem_wdata[k], mem_wr[k], busy[k], done[k], err[k]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_store_table(input int k);
      logic [1:0]  tt  [6] = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
      logic [31:0] aa  [6] = '{32'h10, 32'h102, 32'h202, 32'h203, 32'h300, 32'h402};
      logic [31:0] dd  [6] = '{32'hDEADBEEF, 32'hAABBCC5A, 32'h0000BEEF, 32'h0000BEEF, 32'h12345678, 32'h0BADCAFE};
      logic [31:0] pre [6] = '{32'h01010101, 32'h11223344, 32'h12345678, 32'hCAFEF00D, 32'h55555555, 32'h77777777};
      logic [31:0] ew  [6] = '{32'hDEADBEEF, 32'h115A3344, 32'hBEEF5678, 32'hCAFEF00D, 32'h55555555, 32'h77777777};
      logic        ee  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int dc, wc, ab, ec;
      logic e, ia;
      logic [31:0] wd, wa, a;
      for (int i = 0; i < 6; i++) begin
         a = aa[i];
         mem[k][a[11:2]] = pre[i];
         issue(k, tt[i], a, dd[i], dc, e, wc, wd, wa, ab, ia);
         ec = ee[i] ? 1 : ((tt[i] == 2'd0) ? 2 : 3 + lat_of(k));
         total++; if (dc !== ec) begin bad++; $display("FAIL tbl_done_cycle k=%0d i=%0d got %0d want %0d", k, i, dc, ec); end
         total++; if (e !== ee[i]) begin bad++; $display("FAIL tbl_err k=%0d i=%0d got %b want %b", k, i, e, ee[i]); end
         total++; if (wc !== (ee[i] ? 0 : 1)) begin bad++; $display("FAIL tbl_wr_count k=%0d i=%0d got %0d want %0d", k, i, wc, ee[i] ? 0 : 1); end
         total++; if (mem[k][a[11:2]] !== ew[i]) begin bad++; $display("FAIL tbl_mem_word k=%0d i=%0d got %h want %h", k, i, mem[k][a[11:2]], ew[i]); end
         total++; if (ab !== 0) begin bad++; $display("FAIL tbl_mem_addr k=%0d i=%0d got %0d bad cycles want 0", k, i, ab); end
         total++; if (ia !== 1'b1) begin bad++; $display("FAIL tbl_idle_after k=%0d i=%0d got %b want 1", k, i, ia); end
         if (!ee[i]) begin
            total++; if (wa !== {a[31:2], 2'b00}) begin bad++; $display("FAIL tbl_wr_addr k=%0d i=%0d got %h want %h", k, i, wa, {a[31:2], 2'b00}); end
         end
      end
   endtask

   task automatic test_random(input int k);
      int dc, wc, ab;
      logic e, ia, lg;
      logic [1:0]  t;
      logic [31:0] a, d, old, expw, wd, wa;
      for (int i = 0; i < 30; i++) begin
         t = 2'($urandom_range(0, 3));
         a = $urandom;
         d = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (t == 2'd0) a[1:0] = 2'b00;
            if (t == 2'd1) a[0] = 1'b0;
         end
         lg   = legal(t, a);
         old  = mem[k][a[11:2]];
         expw = lg ? model_word(t, a, d, old) : old;
         issue(k, t, a, d, dc, e, wc, wd, wa, ab, ia);
         total++; if (dc !== exp_cycles(k, t, a)) begin bad++; $display("FAIL rnd_done_cycle k=%0d t=%0d a=%h got %0d want %0d", k, t, a, dc, exp_cycles(k, t, a)); end
         total++; if (e !== !lg) begin bad++; $display("FAIL rnd_err k=%0d t=%0d a=%h got %b want %b", k, t, a, e, !lg); end
         total++; if (wc !== (lg ? 1 : 0)) begin bad++; $display("FAIL rnd_wr_count k=%0d t=%0d a=%h got %0d want %0d", k, t, a, wc, lg ? 1 : 0); end
         total++; if (mem[k][a[11:2]] !== expw) begin bad++; $display("FAIL rnd_mem_word k=%0d t=%0d a=%h got %h want %h", k, t, a, mem[k][a[11:2]], expw); end
         total++; if (ab !== 0 || ia !== 1'b1) begin bad++; $display("FAIL rnd_addr_idle k=%0d t=%0d a=%h got bad=%0d idle=%b want 0/1", k, t, a, ab, ia); end
      end
   endtask

   task automatic test_reset_mid(input int k);
      logic [31:0] a1 = 32'h506;
      logic [31:0] a2 = 32'h600;
      logic [31:0] o1, d2, wd, wa;
      int dc, wc, ab;
      logic e, ia;
      o1 = $urandom;
      mem[k][a1[11:2]] = o1;
      @(negedge clk);
      store_type = 2'd2; addr = a1; wdata = 32'h0000_00C3; start[k] = 1'b1;
      tick(k);
      start[k] = 1'b0;
      tick(k);
      #2 reset = 1'b0;
      #1;
      total++;
      if ({mem_addr[k], mem_wdata[k], mem_wr[k], busy[k], done[k], err[k]} !== 68'h0) begin
         bad++;
         $display("FAIL midreset_outputs k=%0d got addr=%h wdata=%h wr=%b busy=%b done=%b err=%b want all 0",
                  k, mem_addr[k], mem_wdata[k], mem_wr[k], busy[k], done[k], err[k]);
      end
      tick(k); tick(k);
      reset = 1'b1;
      tick(k); tick(k);
      total++; if (mem[k][a1[11:2]] !== o1) begin bad++; $display("FAIL midreset_no_write k=%0d got %h want %h", k, mem[k][a1[11:2]], o1); end
      d2 = $urandom;
      issue(k, 2'd0, a2, d2, dc, e, wc, wd, wa, ab, ia);
      total++; if (dc !== 2 || e !== 1'b0) begin bad++; $display("FAIL after_reset_sw k=%0d got cycle=%0d err=%b want 2/0", k, dc, e); end
      total++; if (mem[k][a2[11:2]] !== d2) begin bad++; $display("FAIL after_reset_mem k=%0d got %h want %h", k, mem[k][a2[11:2]], d2); end
   endtask

   task automatic test_busy_start(input int k);
      logic [31:0] a1 = 32'h702;
      logic [31:0] a2 = 32'h800;
      logic [31:0] o1, o2, d1, d2;
      int wc, dc;
      o1 = $urandom; o2 = $urandom; d1 = $urandom; d2 = $urandom;
      mem[k][a1[11:2]] = o1;
      mem[k][a2[11:2]] = o2;
      @(negedge clk);
      store_type = 2'd1; addr = a1; wdata = d1; start[k] = 1'b1;
      tick(k);
      // start stays high through busy, DONE and the following IDLE cycle
      store_type = 2'd0; addr = a2; wdata = d2;
      wc = 0; dc = -1;
      for (int c = 1; c <= 12; c++) begin
         if (mem_wr[k] === 1'b1) wc++;
         if (done[k] === 1'b1) begin dc = c; break; end
         tick(k);
      end
      total++; if (dc !== 3 + lat_of(k)) begin bad++; $display("FAIL busy_done_cycle k=%0d got %0d want %0d", k, dc, 3 + lat_of(k)); end
      tick(k);
      total++; if (wc !== 1 || busy[k] !== 1'b0) begin bad++; $display("FAIL busy_ignored k=%0d got wr=%0d busy=%b want 1/0", k, wc, busy[k]); end
      total++; if (mem[k][a1[11:2]] !== model_word(2'd1, a1, d1, o1)) begin bad++; $display("FAIL busy_sh_word k=%0d got %h want %h", k, mem[k][a1[11:2]], model_word(2'd1, a1, d1, o1)); end
      total++; if (mem[k][a2[11:2]] !== o2) begin bad++; $display("FAIL busy_no_early_sw k=%0d got %h want %h", k, mem[k][a2[11:2]], o2); end
      tick(k);
      start[k] = 1'b0;
      total++; if (mem_wr[k] !== 1'b1 || mem_addr[k] !== a2) begin bad++; $display("FAIL idle_start_accept k=%0d got wr=%b addr=%h want 1/%h", k, mem_wr[k], mem_addr[k], a2); end
      tick(k);
      total++; if (done[k] !== 1'b1 || err[k] !== 1'b0) begin bad++; $display("FAIL idle_start_done k=%0d got done=%b err=%b want 1/0", k, done[k], err[k]); end
      total++; if (mem[k][a2[11:2]] !== d2) begin bad++; $display("FAIL idle_start_mem k=%0d got %h want %h", k, mem[k][a2[11:2]], d2); end
      tick(k);
   endtask

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 1024; i++) mem[k][i] = $urandom;
      test_reset();
      for (int k = 0; k < 2; k++) begin
         test_store_table(k);
         test_random(k);
         test_reset_mid(k);
         test_busy_start(k);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
